br_update_queue: RTL

- In-order queue of in-flight conditional branches, placed between dispatch/branch-execute and the branch predictor's commit-side update port.
- Allocates one entry per dispatched branch, carrying the fetch PC, the GHR snapshot and the prediction.
- Accepts out-of-order resolutions from the branch unit.
- Retires resolved entries in program order as single-cycle predictor update pulses (com_br/pc/ghr/jmpaddr/jmpcond), and flags mispredictions with a redirect PC.

---
 rtl/br_update_queue_pkg.sv | 24 ++
 rtl/br_update_queue.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/br_update_queue_pkg.sv
// Shared sizing for the branch update queue. The core-wide widths are
// normally provided by constants.vh; fallbacks keep this slice self-contained.
`ifndef RV32_PC_WIDTH
`define RV32_PC_WIDTH 32
`endif
`ifndef GSH_GHR_WIDTH
`define GSH_GHR_WIDTH 8
`endif
`ifndef GSH_PHT_ENT_SEL
`define GSH_PHT_ENT_SEL 8
`endif
`ifndef BUQ_DEPTH
`define BUQ_DEPTH 8
`endif
`ifndef BUQ_TAG_WIDTH
`define BUQ_TAG_WIDTH 3
`endif

package br_update_queue_pkg;
  localparam int BUQ_DEPTH = `BUQ_DEPTH;
  localparam int BUQ_PC_W  = `RV32_PC_WIDTH;
  localparam int BUQ_GHR_W = `GSH_GHR_WIDTH;
  localparam int BUQ_TAG_W = `BUQ_TAG_WIDTH;
endpackage

// File: rtl/br_update_queue.sv
// In-order queue of in-flight branches: allocate at dispatch, resolve out of
// order, retire in program order as one-cycle predictor update pulses.
module br_update_queue
  import br_update_queue_pkg::*;
#(
  parameter int DEPTH = BUQ_DEPTH,
  parameter int PC_W  = BUQ_PC_W,
  parameter int GHR_W = BUQ_GHR_W,
  parameter int TAG_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_alloc_vld,
  input  logic [PC_W-1:0]  i_alloc_pc,
  input  logic [GHR_W-1:0] i_alloc_ghr,
  input  logic             i_alloc_pred_jmp,
  input  logic [PC_W-1:0]  i_alloc_pred_addr,
  output logic [TAG_W-1:0] o_alloc_tag,
  output logic             o_full,
  input  logic             i_res_vld,
  input  logic [TAG_W-1:0] i_res_tag,
  input  logic             i_res_jmpcond,
  input  logic [PC_W-1:0]  i_res_jmpaddr,
  input  logic             i_com_rdy,
  output logic             o_com_br,
  output logic [PC_W-1:0]  o_com_pc,
  output logic [GHR_W-1:0] o_com_ghr,
  output logic [PC_W-1:0]  o_com_jmpaddr,
  output logic             o_com_jmpcond,
  output logic             o_mispred,
  output logic [PC_W-1:0]  o_redirect_pc,
  output logic             o_empty
);

  function automatic logic isMispred(input logic predJmp, input logic [PC_W-1:0] predAddr,
                                     input logic jmpCond, input logic [PC_W-1:0] jmpAddr);
    return (predJmp != jmpCond) || (jmpCond && (predAddr != jmpAddr));
  endfunction

  logic [TAG_W:0]   r_head, r_tail;
  logic             r_valid    [DEPTH];
  logic             r_done     [DEPTH];
  logic [PC_W-1:0]  r_pc       [DEPTH];
  logic [GHR_W-1:0] r_ghr      [DEPTH];
  logic             r_predJmp  [DEPTH];
  logic [PC_W-1:0]  r_predAddr [DEPTH];
  logic             r_jmpCond  [DEPTH];
  logic [PC_W-1:0]  r_jmpAddr  [DEPTH];

  logic             r_comBr, r_comJmpCond, r_mispred;
  logic [PC_W-1:0]  r_comPc, r_comJmpAddr, r_redirectPc;
  logic [GHR_W-1:0] r_comGhr;

  logic [TAG_W-1:0] w_headIdx, w_tailIdx;
  logic             w_empty, w_full, w_doAlloc, w_doRes, w_doRetire;

  assign w_headIdx  = r_head[TAG_W-1:0];
  assign w_tailIdx  = r_tail[TAG_W-1:0];
  assign w_empty    = (r_head == r_tail);
  assign w_full     = (w_headIdx == w_tailIdx) && (r_head[TAG_W] != r_tail[TAG_W]);
  // Flush wins over every other same-cycle action.
  assign w_doAlloc  = i_alloc_vld && !w_full && !i_flush;
  assign w_doRes    = i_res_vld && r_valid[i_res_tag] && !i_flush;
  assign w_doRetire = r_valid[w_headIdx] && r_done[w_headIdx] && i_com_rdy && !i_flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head <= '0;
      r_tail <= '0;
    end else if (i_flush) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (w_doAlloc)  r_tail <= r_tail + 1'b1;
      if (w_doRetire) r_head <= r_head + 1'b1;
    end
  end

  // Retire clears the head before a same-cycle resolve could touch it; the
  // head only becomes eligible from its registered done bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_valid[i]    <= 1'b0;
        r_done[i]     <= 1'b0;
        r_pc[i]       <= '0;
        r_ghr[i]      <= '0;
        r_predJmp[i]  <= 1'b0;
        r_predAddr[i] <= '0;
        r_jmpCond[i]  <= 1'b0;
        r_jmpAddr[i]  <= '0;
      end
    end else if (i_flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_valid[i] <= 1'b0;
        r_done[i]  <= 1'b0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_doRes && (i_res_tag == TAG_W'(i))) begin
          r_done[i]    <= 1'b1;
          r_jmpCond[i] <= i_res_jmpcond;
          r_jmpAddr[i] <= i_res_jmpaddr;
        end
        if (w_doRetire && (w_headIdx == TAG_W'(i))) begin
          r_valid[i] <= 1'b0;
          r_done[i]  <= 1'b0;
        end
        if (w_doAlloc && (w_tailIdx == TAG_W'(i))) begin
          r_valid[i]    <= 1'b1;
          r_done[i]     <= 1'b0;
          r_pc[i]       <= i_alloc_pc;
          r_ghr[i]      <= i_alloc_ghr;
          r_predJmp[i]  <= i_alloc_pred_jmp;
          r_predAddr[i] <= i_alloc_pred_addr;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_comBr      <= 1'b0;
      r_mispred    <= 1'b0;
      r_comPc      <= '0;
      r_comGhr     <= '0;
      r_comJmpAddr <= '0;
      r_comJmpCond <= 1'b0;
      r_redirectPc <= '0;
    end else begin
      r_comBr <= w_doRetire;
      if (w_doRetire) begin
        r_comPc      <= r_pc[w_headIdx];
        r_comGhr     <= r_ghr[w_headIdx];
        r_comJmpAddr <= r_jmpAddr[w_headIdx];
        r_comJmpCond <= r_jmpCond[w_headIdx];
        r_mispred    <= isMispred(r_predJmp[w_headIdx], r_predAddr[w_headIdx],
                                  r_jmpCond[w_headIdx], r_jmpAddr[w_headIdx]);
        r_redirectPc <= r_jmpCond[w_headIdx] ? r_jmpAddr[w_headIdx]
                                             : r_pc[w_headIdx] + PC_W'(4);
      end else begin
        r_mispred <= 1'b0;
      end
    end
  end

  assign o_alloc_tag   = w_tailIdx;
  assign o_full        = w_full;
  assign o_empty       = w_empty;
  assign o_com_br      = r_comBr;
  assign o_com_pc      = r_comPc;
  assign o_com_ghr     = r_comGhr;
  assign o_com_jmpaddr = r_comJmpAddr;
  assign o_com_jmpcond = r_comJmpCond;
  assign o_mispred     = r_mispred;
  assign o_redirect_pc = r_redirectPc;

endmodule
